serial_twos_comp_n: RTL and testbench

- Parametrised, bit-serial two's complementer built around a 2-state Mealy FSM; the next generation of the team's fixed 4-bit Mealy complementer.
- Accepts a WIDTH-bit word with a start/busy/done handshake and processes it LSB-first, one bit per clock.
- Exposes both a per-bit serial output stream and the assembled parallel result.
- Adds a pass-through mode and detection of negation overflow (most-negative input).

---
 rtl/twos_comp_pkg.sv | 12 +
 rtl/twos_comp_bit_fsm.sv | 29 ++
 rtl/serial_twos_comp_n.sv | 88 ++++++++
 tb/tb_serial_twos_comp_n.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/twos_comp_pkg.sv
// twos_comp_pkg: shared state encodings and width bounds for the serial two's complementer.
package twos_comp_pkg;

    typedef enum logic {
        ST_COPY   = 1'b0,
        ST_INVERT = 1'b1
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/twos_comp_bit_fsm.sv
// twos_comp_bit_fsm: 2-state Mealy cell, copies bits up to and including the first 1, then inverts.
module twos_comp_bit_fsm
    import twos_comp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic b,
    input  logic neg,
    output logic sout,
    output logic state
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_COPY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = clr ? ST_COPY : (en && b && state_q == ST_COPY) ? ST_INVERT : state_q;
        sout    = (neg && state_q == ST_INVERT) ? ~b : b;
    end

    assign state = state_q;

endmodule

// File: rtl/serial_twos_comp_n.sv
// serial_twos_comp_n: LSB-first bit-serial two's complementer with start/busy/done handshake,
// pass-through mode and most-negative overflow flag.
module serial_twos_comp_n
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             neg_en,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             ovf
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_twos_comp_n: WIDTH out of range");
    end

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d, res_q, res_d, dout_q, dout_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, neg_q, neg_d;
    logic             accept, last, fsm_sout, fsm_state;

    twos_comp_bit_fsm u_fsm (
        .clk   (clk),
        .rst   (rst),
        .en    (busy_q),
        .clr   (accept),
        .b     (sr_q[0]),
        .neg   (neg_q),
        .sout  (fsm_sout),
        .state (fsm_state)
    );

    always_comb begin
        accept  = start && !busy_q;
        last    = busy_q && cnt_q == LAST;
        shifted = {fsm_sout, res_q[WIDTH-1:1]};
        sr_d    = accept ? din : busy_q ? {1'b0, sr_q[WIDTH-1:1]} : sr_q;
        res_d   = busy_q ? shifted : res_q;
        dout_d  = last ? shifted : dout_q;
        cnt_d   = accept ? '0 : busy_q ? cnt_q + CW'(1) : cnt_q;
        busy_d  = accept || (busy_q && !last);
        done_d  = last;
        neg_d   = accept ? neg_en : neg_q;
        // Overflow: the MSB is the first 1 seen, so negation maps the word onto itself.
        ovf_d   = last ? (neg_q && sr_q[0] && fsm_state == ST_COPY) : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            res_q  <= '0;
            dout_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            res_q  <= res_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            neg_q  <= neg_d;
        end
    end

    assign busy       = busy_q;
    assign sout       = fsm_sout;
    assign sout_valid = busy_q;
    assign dout       = dout_q;
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// tb_serial_twos_comp_n: scoreboard bench for WIDTH=4 and WIDTH=8 instances.
module tb_serial_twos_comp_n;
    import twos_comp_pkg::*;

    typedef struct {
        logic [31:0] dout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, neg4 = 1'b0, start8 = 1'b0, neg8 = 1'b0;
    logic [3:0] din4 = '0, dout4, s4 = '0;
    logic [7:0] din8 = '0, dout8, s8 = '0;
    logic       busy4, sout4, sv4, done4, ovf4, pd4 = 1'b0;
    logic       busy8, sout8, sv8, done8, ovf8, pd8 = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    exp_t       q4[$];
    exp_t       q8[$];

    serial_twos_comp_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .neg_en(neg4), .din(din4), .busy(busy4),
        .sout(sout4), .sout_valid(sv4), .dout(dout4), .done(done4), .ovf(ovf4)
    );

    serial_twos_comp_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .neg_en(neg8), .din(din8), .busy(busy8),
        .sout(sout8), .sout_valid(sv8), .dout(dout8), .done(done8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int w, input logic [31:0] d, input logic n, input int acc);
        exp_t        e;
        logic [31:0] m;
        m      = (32'd1 << w) - 32'd1;
        e.dout = (n ? (32'd0 - d) : d) & m;
        e.ovf  = n && ((d & m) == (32'd1 << (w - 1)));
        e.acc  = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        chk("sout_valid4", sv4, busy4);
        if (busy4) s4 = {sout4, s4[3:1]};
        if (done4) begin
            chk("done_pulse4", pd4, 1'b0);
            if (q4.size() == 0) chk("spurious_done4", done4, 1'b0);
            else begin
                e = q4.pop_front();
                chk("dout4", dout4, e.dout);
                chk("ovf4", ovf4, e.ovf);
                chk("sout_stream4", s4, e.dout);
                chk("latency4", cyc - e.acc, 4);
            end
        end
        pd4 = done4;
    end

    always @(negedge clk) begin
        exp_t e;
        chk("sout_valid8", sv8, busy8);
        if (busy8) s8 = {sout8, s8[7:1]};
        if (done8) begin
            chk("done_pulse8", pd8, 1'b0);
            if (q8.size() == 0) chk("spurious_done8", done8, 1'b0);
            else begin
                e = q8.pop_front();
                chk("dout8", dout8, e.dout);
                chk("ovf8", ovf8, e.ovf);
                chk("sout_stream8", s8, e.dout);
                chk("latency8", cyc - e.acc, 8);
            end
        end
        pd8 = done8;
    end

    // Called at posedge+1; holds start for exactly one edge and returns just after it.
    task automatic go4(input logic [3:0] d, input logic n, input logic push);
        start4 = 1'b1;
        din4   = d;
        neg4   = n;
        if (push) q4.push_back(mk(4, 32'(d), n, cyc + 1));
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic go8(input logic [7:0] d, input logic n);
        start8 = 1'b1;
        din8   = d;
        neg8   = n;
        q8.push_back(mk(8, 32'(d), n, cyc + 1));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic word4(input logic [3:0] d, input logic n);
        go4(d, n, 1'b1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic word8(input logic [7:0] d, input logic n);
        go8(d, n);
        repeat (9) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_dout4", dout4, 4'h0);
        chk("rst_ovf4", ovf4, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_dout8", dout8, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        word4(4'b1010, 1'b1);
        word4(4'b0001, 1'b1);
        go4(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_copy_state", dut4.u_fsm.state_q, ST_COPY);
        end
        repeat (2) @(posedge clk);
        #1;
        word4(4'b1000, 1'b1);
        word4(4'b1000, 1'b0);
        word4(4'b1010, 1'b0);
        // Start while busy must be ignored; start in the done cycle must be taken.
        go4(4'b1010, 1'b1, 1'b1);
        @(posedge clk); #1;
        go4(4'b0011, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_cycle_start", done4, 1'b1);
        go4(4'b0011, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        // Reset mid-word aborts without a done pulse.
        go4(4'b1010, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy4, 1'b0);
        chk("abort_dout", dout4, 4'h0);
        chk("abort_done", done4, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        word4(4'b0101, 1'b1);
        for (int i = 0; i < 4; i++) word4(4'($urandom_range(0, 15)), 1'(i));
        word8(8'h01, 1'b1);
        word8(8'h80, 1'b1);
        word8(8'h80, 1'b0);
        word8(8'h5A, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("drain4", q4.size(), 0);
        chk("drain8", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
